// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, default width.
// Optional flag outputs are enabled by defining ALU_FLAGS_EN.
package alu_pkg;

   localparam int ALU_NUM_BITS = 4;

   // Opcode bits are {s0,s1,s2}, s0 is the MSB.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ADD/SUB/INC/DEC go through the adder; the upper four opcodes do not.
   function automatic logic op_is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result channels of the ALU command sequencer.
// res_zero/res_ovf exist only when ALU_FLAGS_EN is defined.
interface alu_cmd_sequencer_if
   import alu_pkg::*;
#(
   parameter int NUM_BITS = ALU_NUM_BITS,
   parameter int CNT_W    = 3
) ();

   // Both channels are valid/ready: a transfer happens on a rising clk edge where
   // valid and ready are both high; the sender holds its payload stable until then.
   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_op;
   logic [NUM_BITS-1:0] cmd_a;
   logic [NUM_BITS-1:0] cmd_b;
   logic [CNT_W-1:0]    cmd_count;

   logic                res_valid;
   logic                res_ready;
   logic [NUM_BITS-1:0] res_data;
   logic                res_carry;
`ifdef ALU_FLAGS_EN
   logic                res_zero;
   logic                res_ovf;
`endif

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry
`ifdef ALU_FLAGS_EN
      , input res_zero, res_ovf
`endif
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, res_ready,
      output cmd_ready, res_valid, res_data, res_carry
`ifdef ALU_FLAGS_EN
      , output res_zero, res_ovf
`endif
   );

endinterface

// File: rtl/alu_cmd_sequencer_alu_step.sv
// One combinational ALU step: y = a OP b with adder carry-out.
// Signed-overflow output o_ovf is present only when ALU_FLAGS_EN is defined.
module alu_step
   import alu_pkg::*;
#(
   parameter int NUM_BITS = ALU_NUM_BITS
) (
   input  logic [2:0]          i_op,
   input  logic [NUM_BITS-1:0] i_a,
   input  logic [NUM_BITS-1:0] i_b,
   output logic [NUM_BITS-1:0] o_y,
   output logic                o_carry
`ifdef ALU_FLAGS_EN
   , output logic              o_ovf
`endif
);

   localparam int MSB = NUM_BITS - 1;

   logic [NUM_BITS-1:0] w_opnd;
   logic                w_cin;
   logic [NUM_BITS:0]   w_sum;
   logic [NUM_BITS-1:0] w_shr;

   // Every arithmetic op is a + operand + cin on one shared adder.
   always_comb begin
      w_opnd = '0;
      w_cin  = 1'b0;
      case (i_op)
         OP_ADD:  w_opnd = i_b;
         OP_SUB:  begin
            w_opnd = ~i_b;
            w_cin  = 1'b1;
         end
         OP_INC:  w_cin  = 1'b1;
         OP_DEC:  w_opnd = '1;
         default: w_opnd = '0;
      endcase
   end

   assign w_sum = {1'b0, i_a} + {1'b0, w_opnd} + {{NUM_BITS{1'b0}}, w_cin};
   assign w_shr = $unsigned($signed(i_a) >>> 1);

   always_comb begin
      o_y     = '0;
      o_carry = 1'b0;
      case (i_op)
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_XOR:  o_y = i_a ^ i_b;
         OP_SHR:  o_y = w_shr;
         default: begin
            o_y     = w_sum[NUM_BITS-1:0];
            o_carry = w_sum[NUM_BITS];
         end
      endcase
   end

`ifdef ALU_FLAGS_EN
   assign o_ovf = op_is_arith(i_op) && (i_a[MSB] == w_opnd[MSB]) && (w_sum[MSB] != i_a[MSB]);
`endif

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Iterative ALU sequencer: takes {op, A, B, count}, runs acc <= acc OP B count+1 times, returns the result.
// Define ALU_FLAGS_EN to add the registered res_zero/res_ovf outputs.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int NUM_BITS = ALU_NUM_BITS,
   parameter int CNT_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_cmd_sequencer_if.slave    io_bus,
   output state_t                o_state
);

   state_t              r_state;
   logic [2:0]          r_op;
   logic [NUM_BITS-1:0] r_b;
   logic [NUM_BITS-1:0] r_acc;
   logic                r_carry;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_cnt_max;
   logic                r_cmd_ready;
   logic                r_res_valid;
`ifdef ALU_FLAGS_EN
   logic                r_zero;
   logic                r_ovf;
   logic                w_ovf;
`endif

   logic [NUM_BITS-1:0] w_y;
   logic                w_carry;

   alu_step #(.NUM_BITS(NUM_BITS)) u_step (
      .i_op    (r_op),
      .i_a     (r_acc),
      .i_b     (r_b),
      .o_y     (w_y),
      .o_carry (w_carry)
`ifdef ALU_FLAGS_EN
      , .o_ovf (w_ovf)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ADD;
         r_b         <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_cnt_max   <= '0;
         r_cmd_ready <= 1'b1;
         r_res_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_bus.cmd_valid && r_cmd_ready) begin
                  r_op        <= io_bus.cmd_op;
                  r_b         <= io_bus.cmd_b;
                  r_cnt_max   <= io_bus.cmd_count;
                  r_acc       <= io_bus.cmd_a;
                  r_cnt       <= '0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_acc   <= w_y;
               r_carry <= w_carry;
`ifdef ALU_FLAGS_EN
               r_zero  <= (w_y == '0);
               r_ovf   <= w_ovf;
`endif
               // The step whose counter matches the latched count is the last one.
               if (r_cnt == r_cnt_max) begin
                  r_res_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (io_bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_bus.cmd_ready = r_cmd_ready;
   assign io_bus.res_valid = r_res_valid;
   assign io_bus.res_data  = r_acc;
   assign io_bus.res_carry = r_carry;
`ifdef ALU_FLAGS_EN
   assign io_bus.res_zero  = r_zero;
   assign io_bus.res_ovf   = r_ovf;
`endif
   assign o_state = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed cases, backpressure, reset abort, random commands.
// Flag outputs are checked as well when ALU_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int NB = 4;
   localparam int CW = 3;
   localparam int W  = NB + 3;

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.NUM_BITS(NB), .CNT_W(CW)) bus ();

   alu_cmd_sequencer #(.NUM_BITS(NB), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_bus  (bus),
      .o_state (dbg_state)
   );

   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           accept_cyc = 0;
   bit           rand_rr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Packed expectation {ovf, zero, carry, data}; flags read as 0 when not built.
   function automatic logic [W-1:0] mk(input int data, input bit c, input bit z, input bit ov);
      logic [W-1:0] r;
      r = W'(data % (1 << NB));
      r[NB] = c;
`ifdef ALU_FLAGS_EN
      r[NB+1] = z;
      r[NB+2] = ov;
`else
      r[NB+1] = 1'b0;
      r[NB+2] = 1'b0 & (z | ov);
`endif
      return r;
   endfunction

   function automatic logic [W-1:0] actual();
`ifdef ALU_FLAGS_EN
      return {bus.res_ovf, bus.res_zero, bus.res_carry, bus.res_data};
`else
      return {2'b00, bus.res_carry, bus.res_data};
`endif
   endfunction

   // Reference model: plain integer arithmetic, one loop iteration per step.
   function automatic logic [W-1:0] model(input logic [2:0] op, input int a, input int b, input int cnt);
      int m = 1 << NB;
      int acc = a;
      int s, sa, sb, r;
      bit c = 1'b0;
      bit ov = 1'b0;
      bit arith;
      for (int i = 0; i <= cnt; i++) begin
         sa = (acc >= m / 2) ? acc - m : acc;
         sb = (b >= m / 2) ? b - m : b;
         arith = 1'b1;
         s = 0;
         r = 0;
         case (op)
            OP_ADD: begin s = acc + b;           r = sa + sb; end
            OP_SUB: begin s = acc + (m - 1 - b) + 1; r = sa - sb; end
            OP_INC: begin s = acc + 1;           r = sa + 1;  end
            OP_DEC: begin s = acc + m - 1;       r = sa - 1;  end
            OP_AND: begin arith = 1'b0; acc = acc & b; end
            OP_OR:  begin arith = 1'b0; acc = acc | b; end
            OP_XOR: begin arith = 1'b0; acc = acc ^ b; end
            default: begin arith = 1'b0; acc = (acc >> 1) | (acc & (m / 2)); end
         endcase
         if (arith) begin
            c   = (s >= m);
            acc = s % m;
            ov  = (r < -(m / 2)) || (r >= m / 2);
         end else begin
            c  = 1'b0;
            ov = 1'b0;
         end
      end
      return mk(acc, c, acc == 0, ov);
   endfunction

   task automatic send_cmd(input logic [2:0] op, input int a, input int b, input int cnt,
                           input logic [W-1:0] exp);
      int n = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = NB'(a);
      bus.cmd_b     = NB'(b);
      bus.cmd_count = CW'(cnt);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) begin
         fail_now("cmd_accept_timeout");
         bus.cmd_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      lat_q.push_back(cnt + 1);
      @(posedge clk);
      #1;
      accept_cyc    = cyc;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'($urandom_range(0, 7));
      bus.cmd_b     = NB'($urandom_range(0, 15));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus.res_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now(name);
   endtask

   // Monitor: latency on rising res_valid, hold stability while stalled, result at handshake.
   logic         prev_valid = 1'b0;
   logic [W-1:0] held;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.res_valid) begin
            check("cmd_ready_low_with_result", int'(bus.cmd_ready), 0);
            if (!prev_valid) begin
               if (lat_q.size() == 0) fail_now("unexpected_result");
               else check("latency", cyc - accept_cyc, lat_q.pop_front());
            end else begin
               check("result_hold_stable", int'(actual()), int'(held));
            end
            held = actual();
            if (bus.res_ready) begin
               if (exp_q.size() == 0) fail_now("stale_result");
               else check("result", int'(actual()), int'(exp_q.pop_front()));
            end
         end
         prev_valid = bus.res_valid;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rr) bus.res_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic [2:0] op;
      int a, b, c, n;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_ADD;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_count = '0;
      bus.res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", int'(bus.cmd_ready), 1);
      check("reset_res_valid", int'(bus.res_valid), 0);
      check("reset_res_data", int'(bus.res_data), 0);
      check("reset_res_carry", int'(bus.res_carry), 0);
      check("reset_state", int'(dbg_state), int'(ST_IDLE));

      send_cmd(OP_ADD, 4'b1001, 4'b0101, 0, mk(4'b1110, 0, 0, 0));
      send_cmd(OP_SUB, 4'b1001, 4'b0101, 0, mk(4'b0100, 1, 0, 1));
      send_cmd(OP_SUB, 4'b0101, 4'b1001, 0, mk(4'b1100, 0, 0, 1));
      send_cmd(OP_INC, 4'b1111, 4'b0000, 0, mk(4'b0000, 1, 1, 0));
      send_cmd(OP_DEC, 4'b0001, 4'b0110, 2, mk(4'b1110, 1, 0, 0));
      send_cmd(OP_SHR, 4'b1001, 4'b0011, 1, mk(4'b1110, 0, 0, 0));
      send_cmd(OP_XOR, 4'b1001, 4'b0101, 1, mk(4'b1001, 0, 0, 0));
      send_cmd(OP_AND, 4'b1101, 4'b0110, 3, mk(4'b0100, 0, 0, 0));
      send_cmd(OP_OR,  4'b1000, 4'b0011, 0, mk(4'b1011, 0, 0, 0));
`ifdef ALU_FLAGS_EN
      send_cmd(OP_ADD, 4'b0111, 4'b0001, 0, mk(4'b1000, 0, 0, 1));
      send_cmd(OP_SUB, 4'b0101, 4'b0101, 0, mk(4'b0000, 1, 1, 0));
`endif
      drain("directed_drain_timeout");

      // Backpressure: hold the result for three cycles, then release it.
      bus.res_ready = 1'b0;
      send_cmd(OP_ADD, 4'b0011, 4'b0010, 0, mk(4'b0101, 0, 0, 0));
      n = 0;
      while (!bus.res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.res_valid) fail_now("bp_result_timeout");
      repeat (3) begin
         @(negedge clk);
         check("bp_res_valid_held", int'(bus.res_valid), 1);
         check("bp_state_done", int'(dbg_state), int'(ST_DONE));
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_after_result", int'(bus.cmd_ready), 1);
      check("bp_res_valid_cleared", int'(bus.res_valid), 0);
      send_cmd(OP_INC, 4'b0100, 4'b0000, 0, mk(4'b0101, 0, 0, 0));
      drain("bp_drain_timeout");

      // Reset in the middle of a long command: nothing may come out afterwards.
      send_cmd(OP_ADD, 4'b0001, 4'b0001, 7, mk(4'b1001, 0, 0, 0));
      repeat (3) @(negedge clk);
      exp_q.delete();
      lat_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_cmd_ready", int'(bus.cmd_ready), 1);
      check("abort_res_valid", int'(bus.res_valid), 0);
      check("abort_res_data", int'(bus.res_data), 0);
      check("abort_state", int'(dbg_state), int'(ST_IDLE));
      repeat (15) @(negedge clk);

      rand_rr = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom_range(0, 15);
         b  = $urandom_range(0, 15);
         c  = $urandom_range(0, 7);
         send_cmd(op, a, b, c, model(op, a, b, c));
      end
      drain("random_drain_timeout");
      rand_rr = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
